// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised FIFO.
// Default geometry and output-mode encodings.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 5;

    localparam int FWFT       = 0;
    localparam int REGISTERED = 1;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO.
// One synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the write port changes it.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO with thresholds, sticky
// error flags, synchronous flush and optional output register.
module fifo_buffer_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int OUTPUT_REG = FWFT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   full_tresh,
    input  logic [ADDR_WIDTH:0]   empty_tresh,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V =
        (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   eff_tresh;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  wr_ok;
    logic                  rd_ok;

    // Out-of-range or zero threshold falls back to full depth.
    always_comb begin
        eff_tresh = full_tresh;
        if (full_tresh == '0 || full_tresh > DEPTH_V) begin
            eff_tresh = DEPTH_V;
        end
    end

    assign empty        = (level == '0);
    assign full         = (level >= eff_tresh);
    assign almost_empty = (level <= empty_tresh);

    assign wr_ok = write_enable && !full && !clear;
    assign rd_ok = read_enable && !empty && !clear;

    // Pointers wrap naturally at DEPTH; flush rewinds both.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
        end else if (clear) begin
            level <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_enable && full) overflow  <= 1'b1;
            if (read_enable && empty) underflow <= 1'b1;
        end
    end

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock     (clock),
        .write_en  (wr_ok),
        .write_addr(wr_ptr),
        .write_data(data_in),
        .read_addr (rd_ptr),
        .read_data (ram_data)
    );

    if (OUTPUT_REG == REGISTERED) begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        // Capture the head on each accepted read; valid for one cycle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (clear) begin
                valid_q <= 1'b0;
            end else if (rd_ok) begin
                dout_q  <= ram_data;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end

        assign data_out   = dout_q;
        assign data_valid = valid_q;
    end else begin : g_fwft
        assign data_out   = ram_data;
        assign data_valid = !empty;
    end

endmodule

// File: doc/fifo_buffer_param.md
# fifo_buffer_param

Parametrised synchronous FIFO, the next generation of the team's 8-bit/32-entry buffer. Width, depth and output mode are parameters. Adds a programmable almost-empty threshold, a fill-level output, sticky overflow/underflow flags, a synchronous flush, and an optional registered read port. It sits between byte/word producers and consumers in a single clock domain.

## Interface
- DATA_WIDTH, 8, data bits per entry
- ADDR_WIDTH, 5, pointer width; DEPTH = 2**ADDR_WIDTH (32)
- OUTPUT_REG, 0, 0 = first-word fall-through (combinational read); 1 = registered read, one-cycle latency
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- write_enable  input  1  write request
- read_enable  input  1  read request
- clear  input  1  synchronous flush
- data_in  input  DATA_WIDTH  write data
- full_tresh  input  ADDR_WIDTH+1  full threshold; 0 or >DEPTH means DEPTH
- empty_tresh  input  ADDR_WIDTH+1  almost-empty threshold
- data_out  output  DATA_WIDTH  read data
- data_valid  output  1  data_out holds a popped/head word
- empty  output  1  level == 0
- full  output  1  level >= effective full threshold
- almost_empty  output  1  level <= empty_tresh
- level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write requested while full
- underflow  output  1  sticky: read requested while empty

## Operation
- Write is accepted iff write_enable && !full. Read is accepted iff read_enable && !empty.
- Write pointer and read pointer are ADDR_WIDTH bits. Each advances by 1 on an accepted operation and wraps modulo DEPTH.
- level changes as follows:
  - accepted write only: +1
  - accepted read only: -1
  - both accepted, or neither: unchanged
- level never exceeds DEPTH and never goes below 0.
- Effective threshold is DEPTH if full_tresh == 0 or full_tresh > DEPTH; otherwise it is full_tresh.
- full uses >=, so lowering the threshold below the current level asserts full immediately. This is combinational from level and full_tresh.
- Simultaneous write and read while full: the read is accepted and the write is rejected. overflow is set.
- Simultaneous write and read while empty: the write is accepted and the read is rejected. underflow is set. In fall-through mode the written word becomes visible the next cycle.
- overflow and underflow stay high until clear or reset.
- clear has priority over write and read. In that cycle it zeroes both pointers, level, overflow, underflow and the registered data_valid. Write and read are ignored that cycle. Memory contents are not cleared.
- In OUTPUT_REG=0 mode:
  - data_out = memory[read_ptr]
  - data_valid = !empty
  - data_out is don't-care while empty
- In OUTPUT_REG=1 mode:
  - An accepted read loads memory[read_ptr] into the output register on that edge.
  - data_valid is high for exactly the following cycle unless another read is accepted.
  - data_out holds its last value otherwise.

## Timing
- Reset (asynchronous on reset_n low) forces:
  - pointers = 0, level = 0, overflow = 0, underflow = 0
  - empty = 1, full = 0, almost_empty = 1
  - data_valid = 0
  - data_out = 0 in registered mode
- Memory is not reset.
- Reset asserted mid-operation discards all contents immediately. The first write after deassertion lands at address 0.
- Write-to-read visibility: a word written at edge N is readable (empty low, data_out valid in fall-through mode) after edge N.
- Read latency:
  - fall-through: 0 cycles, data_out is the head before the read edge
  - registered: data at the cycle following the accepting edge
- Back-to-back reads in registered mode sustain one word per cycle.
- level, empty, full and almost_empty are registered-state-derived. They update on the edge that performs the operation.

## Structure
- Shared package fifo_pkg holds the default DATA_WIDTH and ADDR_WIDTH constants and the OUTPUT_REG mode encodings (FWFT = 0, REGISTERED = 1).
- One sub-module, fifo_ram: simple dual-port array of DEPTH x DATA_WIDTH with one synchronous write port and one asynchronous read port. The registered-output stage stays in fifo_buffer_param.
- Pointer, level and flag logic live in the top module.

## Test plan
- Reset release, then 32 writes (0x00..0x1F) with full_tresh=0 -> full high after the 32nd edge and level=32. A 33rd write sets overflow and leaves level=32.
- Drain 32 reads in FWFT mode -> data_out reads 0x00..0x1F in order, empty after the last one. A further read sets underflow.
- full_tresh=4: write 6 times -> full after the 4th edge, writes 5 and 6 rejected, level=4. Change full_tresh to 3 -> full stays high, level=4.
- Fill level=5, then write+read in the same cycle repeatedly for 40 cycles -> level constant at 5, both pointers wrap, data order preserved.
- OUTPUT_REG=1: write 0xA5 and 0x5A, then read twice back-to-back -> data_valid high for two cycles, data_out 0xA5 then 0x5A, one cycle after each read.
- With level=7 and overflow set, assert clear with write_enable=1 -> next cycle level=0, empty=1, overflow=0, and the write is not stored. Repeat with reset_n pulsed low mid-cycle -> outputs take reset values asynchronously.
